// File: rtl/bitwise_and_32_pkg.sv
// Shared constants and helpers for the bitwise AND block.
// The helper sizes the popcount result so it can hold every count from 0 to WIDTH.
package bitwise_and_32_pkg;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int popcnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bitwise_and_32_flags.sv
// Combinational summary of a vector: all-zero, all-one and count of set bits.
module bitwise_and_32_flags
  import bitwise_and_32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]                   value,
  output logic                               zero,
  output logic                               ones,
  output logic [popcnt_width(WIDTH)-1:0]     popcnt
);

  localparam int PW = popcnt_width(WIDTH);

  assign zero = ~|value;
  assign ones = &value;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + PW'(value[i]);
    end
  end

endmodule

// File: rtl/bitwise_and_32.sv
// Bitwise AND with a combinational result and a one-cycle registered copy.
// Define BITWISE_AND_32_FLAGS_EN to add registered zero/all-ones/popcount flags.
module bitwise_and_32
  import bitwise_and_32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           in_valid,
  output logic [WIDTH-1:0]               out,
  output logic [WIDTH-1:0]               out_q,
  output logic                           out_valid
`ifdef BITWISE_AND_32_FLAGS_EN
  ,
  output logic                           zero_q,
  output logic                           ones_q,
  output logic [popcnt_width(WIDTH)-1:0] popcnt_q
`endif
);

  assign out = a & b;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

`ifdef BITWISE_AND_32_FLAGS_EN
  localparam int PW = popcnt_width(WIDTH);

  logic          zero;
  logic          ones;
  logic [PW-1:0] popcnt;

  // Flags derive from the same AND value that out_q captures on this edge.
  bitwise_and_32_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .value (out),
    .zero  (zero),
    .ones  (ones),
    .popcnt(popcnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q   <= 1'b1;
      ones_q   <= 1'b0;
      popcnt_q <= '0;
    end else if (in_valid) begin
      zero_q   <= zero;
      ones_q   <= ones;
      popcnt_q <= popcnt;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_and_32.sv
// Self-checking bench for bitwise_and_32: directed vectors plus random traffic
// compared against a behavioural model (works with or without BITWISE_AND_32_FLAGS_EN).
module tb_bitwise_and_32;

  localparam int W  = 32;
  localparam int PW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic [W-1:0]  out;
  logic [W-1:0]  out_q;
  logic          out_valid;
`ifdef BITWISE_AND_32_FLAGS_EN
  logic          zero_q;
  logic          ones_q;
  logic [PW-1:0] popcnt_q;
`endif

  bitwise_and_32 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .out      (out),
    .out_q    (out_q),
    .out_valid(out_valid)
`ifdef BITWISE_AND_32_FLAGS_EN
    ,
    .zero_q   (zero_q),
    .ones_q   (ones_q),
    .popcnt_q (popcnt_q)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the registered outputs should show.
  logic [W-1:0] exp_q;
  logic         exp_valid;
  logic         exp_zero;
  logic         exp_ones;
  int           exp_pop;
  logic [W-1:0] comb_seen;
  logic [W-1:0] comb_exp;

  // Drive one cycle of inputs, capture the combinational output before the
  // edge, advance past the edge and update the model from the spec's rules.
  task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tv, input logic tr);
    logic [W-1:0] prod;
    a = ta; b = tb; in_valid = tv; rst = tr;
    #1;
    comb_seen = out;
    comb_exp  = ta & tb;
    @(posedge clk);
    prod = 'x;
    for (int i = 0; i < W; i++) prod[i] = ta[i] && tb[i];
    if (tr) begin
      exp_q = '0; exp_valid = 1'b0; exp_zero = 1'b1; exp_ones = 1'b0; exp_pop = 0;
    end else begin
      exp_valid = tv;
      if (tv) begin
        exp_q    = prod;
        exp_zero = (prod == '0);
        exp_ones = (prod == {W{1'b1}});
        exp_pop  = $countones(prod);
      end
    end
    #1;
    $display("txn t=%0t a=%h b=%h v=%0d rst=%0d out=%h out_q=%h out_valid=%0d",
             $time, ta, tb, tv, tr, comb_seen, out_q, out_valid);
  endtask

  task automatic test_reset;
    step('1, '1, 1'b1, 1'b1);
    step('1, '1, 1'b1, 1'b1);
    vectors++;
    if (comb_seen !== 32'hFFFFFFFF) begin
      miscompares++; $display("FAIL reset_comb out=%h expected=%h", comb_seen, 32'hFFFFFFFF);
    end
    vectors++;
    if (out_q !== '0) begin
      miscompares++; $display("FAIL reset_out_q out_q=%h expected=0", out_q);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid out_valid=%b expected=0", out_valid);
    end
`ifdef BITWISE_AND_32_FLAGS_EN
    vectors++;
    if (zero_q !== 1'b1 || ones_q !== 1'b0 || popcnt_q !== '0) begin
      miscompares++;
      $display("FAIL reset_flags zero=%b ones=%b pop=%0d expected 1 0 0", zero_q, ones_q, popcnt_q);
    end
`endif
    // First accepted input after release appears one cycle later.
    step('1, 32'h0000FFFF, 1'b1, 1'b0);
    vectors++;
    if (out_q !== 32'h0000FFFF || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release out_q=%h valid=%b expected 0000ffff 1", out_q, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] da [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hAAAAAAAA};
    logic [W-1:0] db [5] = '{32'h0000FFFF, 32'hFFFF0000, 32'h00000002, 32'hFFFFFFFF, 32'h55555555};
    logic [W-1:0] dq [5] = '{32'h0000FFFF, 32'hFFFF0000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
    int           dp [5] = '{16, 16, 1, 32, 0};
    for (int i = 0; i < 5; i++) begin
      step(da[i], db[i], 1'b1, 1'b0);
      vectors++;
      if (comb_seen !== dq[i]) begin
        miscompares++; $display("FAIL dir_comb[%0d] out=%h expected=%h", i, comb_seen, dq[i]);
      end
      vectors++;
      if (out_q !== dq[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_reg[%0d] out_q=%h valid=%b expected %h 1", i, out_q, out_valid, dq[i]);
      end
`ifdef BITWISE_AND_32_FLAGS_EN
      vectors++;
      if (popcnt_q !== PW'(dp[i]) || zero_q !== (dp[i] == 0) || ones_q !== (dp[i] == W)) begin
        miscompares++;
        $display("FAIL dir_flags[%0d] pop=%0d zero=%b ones=%b expected pop=%0d",
                 i, popcnt_q, zero_q, ones_q, dp[i]);
      end
`else
      if (dp[i] < 0) $display("unreachable");
`endif
    end
  endtask

  task automatic test_reset_priority;
    step('1, '1, 1'b1, 1'b1);
    vectors++;
    if (comb_seen !== '1 || out_q !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_priority out=%h out_q=%h valid=%b expected ffffffff 0 0",
               comb_seen, out_q, out_valid);
    end
    step(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
    vectors++;
    if (out_q !== 32'h02040608 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_first out_q=%h valid=%b expected 02040608 1", out_q, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] last;
    int           high_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      last = $urandom;
      step(last, 32'hFFFFFFFF, 1'b1, 1'b0);
      if (out_valid === 1'b1) high_cycles++;
      vectors++;
      if (out_q !== last) begin
        miscompares++; $display("FAIL b2b_data[%0d] out_q=%h expected=%h", i, out_q, last);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step($urandom, $urandom, 1'b0, 1'b0);
      if (out_valid === 1'b1) high_cycles++;
      vectors++;
      if (out_q !== last) begin
        miscompares++; $display("FAIL b2b_hold[%0d] out_q=%h expected=%h", i, out_q, last);
      end
    end
    vectors++;
    if (high_cycles != 3) begin
      miscompares++; $display("FAIL b2b_valid_count got=%0d expected=3", high_cycles);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      step($urandom, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      vectors++;
      if (comb_seen !== comb_exp) begin
        miscompares++; $display("FAIL rnd_comb[%0d] out=%h expected=%h", i, comb_seen, comb_exp);
      end
      vectors++;
      if (out_q !== exp_q || out_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL rnd_reg[%0d] out_q=%h valid=%b expected %h %b",
                 i, out_q, out_valid, exp_q, exp_valid);
      end
`ifdef BITWISE_AND_32_FLAGS_EN
      vectors++;
      if (zero_q !== exp_zero || ones_q !== exp_ones || popcnt_q !== PW'(exp_pop)) begin
        miscompares++;
        $display("FAIL rnd_flags[%0d] zero=%b ones=%b pop=%0d expected %b %b %0d",
                 i, zero_q, ones_q, popcnt_q, exp_zero, exp_ones, exp_pop);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; in_valid = 1'b0;
    exp_q = '0; exp_valid = 1'b0; exp_zero = 1'b1; exp_ones = 1'b0; exp_pop = 0;
    test_reset;
    test_directed;
    test_reset_priority;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitwise_and_32.md
BITWISE_AND_32 -- requirements
Module: bitwise_and_32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  single clock; all registers update on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: a  input  WIDTH  operand A.
REQ-005 Port: b  input  WIDTH  operand B.
REQ-006 Port: in_valid  input  1  a/b qualify for capture this cycle.
REQ-007 Port: out  output  WIDTH  combinational result a & b.
REQ-008 Port: out_q  output  WIDTH  registered result.
REQ-009 Port: out_valid  output  1  out_q holds a captured result.
REQ-010 Port: zero_q  output  1  registered flag: captured result is all zeros; present only with BITWISE_AND_32_FLAGS_EN.
REQ-011 Port: ones_q  output  1  registered flag: captured result is all ones; present only with BITWISE_AND_32_FLAGS_EN.
REQ-012 Port: popcnt_q  output  clog2(WIDTH+1)  registered count of set bits in the captured result; present only with BITWISE_AND_32_FLAGS_EN.

Function
REQ-013 out SHALL equal a & b bit-for-bit, purely combinational, zero latency, independent of clk, rst and in_valid.
REQ-014 Bit i of out SHALL be 1 only when a[i] and b[i] are both 1; there is no carry or cross-bit interaction.
REQ-015 On a rising edge with rst=0 and in_valid=1, out_q SHALL load a & b and out_valid SHALL go 1; latency is one cycle.
REQ-016 On a rising edge with rst=0 and in_valid=0, out_q and all flags SHALL hold their values, and out_valid SHALL go 0.
REQ-017 out_valid SHALL be 1 for exactly one cycle per accepted input; back-to-back in_valid cycles SHALL give back-to-back results with no bubbles.
REQ-018 There is no backpressure; every in_valid=1 cycle is accepted.
REQ-019 Flags (when compiled in) SHALL be computed from the same a & b value loaded into out_q on the same edge.
REQ-020 X/Z inputs are outside scope; no X-propagation guarantees are given.

Reset
REQ-021 While rst=1 at a rising edge: out_q=0, out_valid=0, zero_q=1, ones_q=0, popcnt_q=0.
REQ-022 rst SHALL take priority over in_valid on the same edge; inputs presented during reset are discarded.
REQ-023 out (combinational) SHALL remain a & b during reset.

Configuration
REQ-024 Macro BITWISE_AND_32_FLAGS_EN defined: zero_q, ones_q and popcnt_q ports and their registers SHALL exist and behave per REQ-019/021.
REQ-025 Macro undefined: those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package bitwise_and_32_pkg SHALL hold the default width constant (32) and the popcount-width helper function.
REQ-027 One sub-module, bitwise_and_32_flags, SHALL compute zero/all-ones/popcount combinationally from a WIDTH-bit vector; instantiated only under the macro.

Verification
REQ-028 a=FFFFFFFF, b=0000FFFF -> out=0000FFFF immediately; with in_valid=1, out_q=0000FFFF, out_valid=1 next cycle, popcnt_q=16.
REQ-029 a=FFFFFFFF, b=FFFF0000 -> out=FFFF0000; registered out_q=FFFF0000, zero_q=0, ones_q=0.
REQ-030 a=00000003, b=00000002 -> out=00000002; popcnt_q=1 after capture.
REQ-031 a=FFFFFFFF, b=FFFFFFFF, in_valid=1 -> out_q=FFFFFFFF, ones_q=1, popcnt_q=32; then a=AAAAAAAA, b=55555555 -> out=00000000, zero_q=1.
REQ-032 rst=1 with in_valid=1 and a=b=FFFFFFFF -> out=FFFFFFFF, but out_q=0, out_valid=0 after the edge; rst released -> first accepted input appears after one cycle.
REQ-033 in_valid high 3 cycles then low -> out_valid high exactly 3 cycles, out_q holds last result afterwards.
